// File: rtl/classifier_pkg.sv
// rtl/classifier_pkg.sv - shared defaults, FSM states and channel-slice helper for the classifier FC stage
package classifier_pkg;

    localparam int DATA_WIDTH_DEF     = 8;
    localparam int OUTPUT_CHANNEL_DEF = 10;
    localparam int INPUT_LEN_DEF      = 784;
    localparam int ACC_WIDTH_DEF      = 32;
    localparam int SHIFT_DEF          = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2,
        HOLD  = 2'd3
    } fc_state_e;

    // Pull one channel out of a packed vector built with the default widths.
    function automatic logic [DATA_WIDTH_DEF-1:0] ch_slice(
        input logic [DATA_WIDTH_DEF*OUTPUT_CHANNEL_DEF-1:0] vec,
        input int unsigned                                   idx
    );
        return vec[idx*DATA_WIDTH_DEF +: DATA_WIDTH_DEF];
    endfunction

endpackage

// File: rtl/fc_accumulate_if.sv
// rtl/fc_accumulate_if.sv - activation-in / score-out handshake bundle for fc_accumulate
interface fc_accumulate_if
    import classifier_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int OUTPUT_CHANNEL = OUTPUT_CHANNEL_DEF
);
    logic                                 in_valid;
    logic                                 in_ready;
    logic [DATA_WIDTH-1:0]                in_act;
    logic [DATA_WIDTH*OUTPUT_CHANNEL-1:0] in_weight;
    logic                                 in_last;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [DATA_WIDTH*OUTPUT_CHANNEL-1:0] out_data;
    logic                                 frame_err;

    modport slave (
        input  in_valid, in_act, in_weight, in_last, out_ready,
        output in_ready, out_valid, out_data, frame_err
    );

    modport master (
        output in_valid, in_act, in_weight, in_last, out_ready,
        input  in_ready, out_valid, out_data, frame_err
    );
endinterface

// File: rtl/fc_scale_clamp.sv
// rtl/fc_scale_clamp.sv - per-channel shift, optional round-half-up (FC_ROUND_EN), ReLU and saturate
module fc_scale_clamp #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int SHIFT      = 7
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    output logic        [DATA_WIDTH-1:0] score
);
    // One extra bit so the rounding add can never wrap the sign.
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((64'd1 << DATA_WIDTH) - 64'd1);
`ifdef FC_ROUND_EN
    localparam int                        RND_SH  = (SHIFT >= 1) ? (SHIFT - 1) : 0;
    localparam logic signed [ACC_WIDTH:0] RND     = (SHIFT >= 1) ? (ACC_WIDTH+1)'(64'd1 << RND_SH) : '0;
`endif

    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] shifted;

    // Widen, optionally bias by half an LSB, shift arithmetically, then clamp to [0, 2^DATA_WIDTH-1].
    always_comb begin
        ext = {acc[ACC_WIDTH-1], acc};
`ifdef FC_ROUND_EN
        ext = ext + RND;
`endif
        shifted = ext >>> SHIFT;
        if (shifted < 0) begin
            score = '0;
        end else if (shifted > SAT_MAX) begin
            score = '1;
        end else begin
            score = shifted[DATA_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/fc_accumulate.sv
// rtl/fc_accumulate.sv - FC output layer: per-beat MAC into signed accumulators, scaled score vector out (FC_ROUND_EN selects rounding)
module fc_accumulate
    import classifier_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int OUTPUT_CHANNEL = OUTPUT_CHANNEL_DEF,
    parameter int INPUT_LEN      = INPUT_LEN_DEF,
    parameter int ACC_WIDTH      = ACC_WIDTH_DEF,
    parameter int SHIFT          = SHIFT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    fc_accumulate_if.slave  bus
);
    localparam int                CNT_W    = $clog2(INPUT_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(INPUT_LEN - 1);
    localparam int                VEC_W    = DATA_WIDTH * OUTPUT_CHANNEL;

    fc_state_e                    state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0]  acc_q [OUTPUT_CHANNEL];
    logic signed [ACC_WIDTH-1:0]  acc_d [OUTPUT_CHANNEL];
    logic signed [2*DATA_WIDTH:0] prod  [OUTPUT_CHANNEL];
    logic [VEC_W-1:0]             out_data_q, out_data_d;
    logic [VEC_W-1:0]             scaled;
    logic                         out_valid_q, out_valid_d;
    logic                         frame_err_q, frame_err_d;
    logic                         accept;
    logic                         last_beat;

    // Beats are taken only in IDLE/ACCUM; held low during reset so nothing is consumed.
    assign bus.in_ready  = ((state_q == IDLE) || (state_q == ACCUM)) && rst_n;
    assign accept        = bus.in_valid && bus.in_ready;
    assign last_beat     = (cnt_q == LAST_CNT);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.frame_err = frame_err_q;

    genvar g;
    generate
        for (g = 0; g < OUTPUT_CHANNEL; g++) begin : g_ch
            fc_scale_clamp #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH),
                .SHIFT      (SHIFT)
            ) u_scale_clamp (
                .acc   (acc_q[g]),
                .score (scaled[g*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    // Next-state, MAC update, framing check and output-vector capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        frame_err_d = frame_err_q;
        for (int i = 0; i < OUTPUT_CHANNEL; i++) begin
            acc_d[i] = acc_q[i];
            prod[i]  = $signed({1'b0, bus.in_act}) * $signed(bus.in_weight[i*DATA_WIDTH +: DATA_WIDTH]);
        end

        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    for (int i = 0; i < OUTPUT_CHANNEL; i++) begin
                        acc_d[i] = acc_q[i] + ACC_WIDTH'(prod[i]);
                    end
                    cnt_d = cnt_q + 1'b1;
                    // in_last is advisory: the counter alone decides where the frame ends.
                    if (bus.in_last != last_beat) begin
                        frame_err_d = 1'b1;
                    end
                    state_d = last_beat ? SCALE : ACCUM;
                end
            end
            SCALE: begin
                out_data_d  = scaled;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                    for (int i = 0; i < OUTPUT_CHANNEL; i++) begin
                        acc_d[i] = '0;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < OUTPUT_CHANNEL; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            for (int i = 0; i < OUTPUT_CHANNEL; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end
endmodule

// File: tb/tb_fc_accumulate.sv
// tb/tb_fc_accumulate.sv - directed self-checking bench for fc_accumulate (SHIFT=0 and SHIFT=1 instances)
module tb_fc_accumulate;
    import classifier_pkg::*;

    localparam int DW = 8;
    localparam int OC = 10;
    localparam int VW = DW * OC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_act = '0;
    logic [VW-1:0] in_weight = '0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fc_accumulate_if #(.DATA_WIDTH(DW), .OUTPUT_CHANNEL(OC)) bus0 ();
    fc_accumulate_if #(.DATA_WIDTH(DW), .OUTPUT_CHANNEL(OC)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_act    = in_act;
    assign bus0.in_weight = in_weight;
    assign bus0.in_last   = in_last;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_act    = in_act;
    assign bus1.in_weight = in_weight;
    assign bus1.in_last   = in_last;
    assign bus1.out_ready = out_ready;

    fc_accumulate #(.DATA_WIDTH(DW), .OUTPUT_CHANNEL(OC), .INPUT_LEN(4), .ACC_WIDTH(32), .SHIFT(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    fc_accumulate #(.DATA_WIDTH(DW), .OUTPUT_CHANNEL(OC), .INPUT_LEN(4), .ACC_WIDTH(32), .SHIFT(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    function automatic logic [VW-1:0] wvec(input int ch, input logic [DW-1:0] w);
        logic [VW-1:0] v;
        v = '0;
        v[ch*DW +: DW] = w;
        return v;
    endfunction

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] act, input logic [VW-1:0] w, input logic last);
        int budget;
        budget    = 50;
        in_act    = act;
        in_weight = w;
        in_last   = last;
        in_valid  = 1'b1;
        while (bus0.in_ready !== 1'b1 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) check("in_ready_timeout", VW'(bus0.in_ready), VW'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the edge that took the final beat.
    task automatic check_latency(input string tag);
        check({tag, "_scale_cycle"}, VW'(bus0.out_valid), VW'(0));
        @(posedge clk); #1;
        check({tag, "_out_valid"}, VW'(bus0.out_valid), VW'(1));
    endtask

    task automatic take_vec(input string tag, input logic [VW-1:0] exp);
        int budget;
        budget = 50;
        while (bus0.out_valid !== 1'b1 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) check({tag, "_timeout"}, VW'(bus0.out_valid), VW'(1));
        check(tag, bus0.out_data, exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drop"}, VW'(bus0.out_valid), VW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic [VW-1:0] hold_data;
        logic [DW-1:0] exp_rnd;

        // Reset state
        #1;
        check("rst_in_ready", VW'(bus0.in_ready), VW'(0));
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", VW'(bus0.out_valid), VW'(0));
        check("rst_out_data",  bus0.out_data,       VW'(0));
        check("rst_frame_err", VW'(bus0.frame_err), VW'(0));
        check("rst_in_ready2", VW'(bus0.in_ready),  VW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", VW'(bus0.in_ready), VW'(1));

        // Basic MAC: 1+2+3+4 on ch0
        for (int a = 1; a <= 4; a++) send_beat(DW'(a), wvec(0, 8'd1), a == 4);
        check_latency("basic");
        take_vec("basic_vec", wvec(0, 8'd10));
        check("basic_frame_err", VW'(bus0.frame_err), VW'(0));

        // ReLU: ch1 = -200 -> 0 ; ch3 = 4*10*3 = 120
        for (int i = 0; i < 4; i++) send_beat(8'd10, wvec(1, 8'hFB) | wvec(3, 8'd3), i == 3);
        check_latency("relu");
        take_vec("relu_vec", wvec(3, 8'd120));

        // Saturation: ch2 = 4*255*127 -> 255 ; ch4 = -1020 -> 0
        for (int i = 0; i < 4; i++) send_beat(8'd255, wvec(2, 8'd127) | wvec(4, 8'hFF), i == 3);
        check_latency("sat");
        take_vec("sat_vec", wvec(2, 8'd255));

        // Backpressure: vector held while out_ready low, pending beat not consumed
        for (int i = 0; i < 4; i++) send_beat(8'd1, wvec(0, 8'd2), i == 3);
        check_latency("bp");
        hold_data = bus0.out_data;
        in_act    = 8'd5;
        in_weight = wvec(0, 8'd1);
        in_last   = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp_out_valid", VW'(bus0.out_valid), VW'(1));
            check("bp_out_data",  bus0.out_data,       wvec(0, 8'd8));
            check("bp_in_ready",  VW'(bus0.in_ready),  VW'(0));
            @(posedge clk); #1;
        end
        check("bp_stable", bus0.out_data, hold_data);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_drop",        VW'(bus0.out_valid), VW'(0));
        check("bp_idle_ready",  VW'(bus0.in_ready),  VW'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(8'd1, wvec(0, 8'd1), i == 2);
        check_latency("bp_next");
        take_vec("bp_next_vec", wvec(0, 8'd8));
        check("bp_frame_err", VW'(bus0.frame_err), VW'(0));

        // Framing error: in_last early on beat 2, frame still completes by count
        send_beat(8'd1, wvec(0, 8'd1), 1'b0);
        send_beat(8'd1, wvec(0, 8'd1), 1'b1);
        check("ferr_set", VW'(bus0.frame_err), VW'(1));
        send_beat(8'd1, wvec(0, 8'd1), 1'b0);
        send_beat(8'd1, wvec(0, 8'd1), 1'b1);
        check_latency("ferr");
        take_vec("ferr_vec", wvec(0, 8'd4));
        check("ferr_sticky", VW'(bus0.frame_err), VW'(1));

        // Reset mid-frame discards the partial frame
        send_beat(8'd9, wvec(0, 8'd9), 1'b0);
        send_beat(8'd9, wvec(0, 8'd9), 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  VW'(bus0.in_ready),  VW'(0));
        check("mid_rst_frame_err", VW'(bus0.frame_err), VW'(0));
        check("mid_rst_out_data",  bus0.out_data,       VW'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send_beat(8'd1, wvec(0, 8'd1), i == 3);
        check_latency("post_rst");
        take_vec("post_rst_vec", wvec(0, 8'd4));

        // Rounding on the SHIFT=1 instance: accumulator 3
`ifdef FC_ROUND_EN
        exp_rnd = 8'd2;
`else
        exp_rnd = 8'd1;
`endif
        send_beat(8'd1, wvec(0, 8'd1), 1'b0);
        send_beat(8'd1, wvec(0, 8'd1), 1'b0);
        send_beat(8'd1, wvec(0, 8'd1), 1'b0);
        send_beat(8'd0, wvec(0, 8'd1), 1'b1);
        check_latency("rnd");
        check("rnd_shift1_ch0", VW'(ch_slice(bus1.out_data, 0)), VW'(exp_rnd));
        take_vec("rnd_shift0_vec", wvec(0, 8'd3));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
